// File: rtl/eaglesong_sponge_ctrl.sv
// Eaglesong sponge controller: absorbs 256-bit rate blocks into a 16-word state,
// sequences the external permutation one round at a time and presents the digest.
module eaglesong_sponge_ctrl #(
   parameter int unsigned NUM_ROUNDS  = 43,
   parameter int unsigned RATE_WORDS  = 8,
   parameter int unsigned STATE_WORDS = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     blk_valid,
   output logic                     blk_ready,
   input  logic [32*RATE_WORDS-1:0] blk_data,
   input  logic                     blk_last,
   output logic [31:0]              perm_state_in [STATE_WORDS],
   output logic [5:0]               perm_round_num,
   output logic                     perm_start,
   input  logic [31:0]              perm_state_out [STATE_WORDS],
   input  logic                     perm_done,
   output logic                     digest_valid,
   output logic [32*RATE_WORDS-1:0] digest,
   input  logic                     digest_ready,
   output logic                     busy
);

   localparam logic [5:0] LastRound = 6'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StWait,
      StOut
   } fsm_e;

   fsm_e        fsm_q, fsm_d;
   logic [5:0]  round_q, round_d;
   logic        last_q, last_d;
   logic [31:0] state_q [STATE_WORDS];
   logic [31:0] state_d [STATE_WORDS];

   // State register, round counter, last flag and sponge state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= StIdle;
         round_q <= '0;
         last_q  <= 1'b0;
         for (int unsigned i = 0; i < STATE_WORDS; i++) begin
            state_q[i] <= '0;
         end
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         last_q  <= last_d;
         state_q <= state_d;
      end
   end

   // Next-state, absorb/write-back datapath and handshake outputs.
   always_comb begin
      fsm_d        = fsm_q;
      round_d      = round_q;
      last_d       = last_q;
      state_d      = state_q;
      blk_ready    = 1'b0;
      perm_start   = 1'b0;
      digest_valid = 1'b0;
      unique case (fsm_q)
         StIdle: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               // Only the rate portion absorbs input; capacity words stay untouched.
               for (int unsigned i = 0; i < RATE_WORDS; i++) begin
                  state_d[i] = state_q[i] ^ blk_data[32*i +: 32];
               end
               last_d  = blk_last;
               round_d = '0;
               fsm_d   = StRun;
            end
         end
         StRun: begin
            perm_start = 1'b1;
            fsm_d      = StWait;
         end
         StWait: begin
            if (perm_done) begin
               state_d = perm_state_out;
               if (round_q == LastRound) begin
                  fsm_d = last_q ? StOut : StIdle;
               end else begin
                  round_d = round_q + 6'd1;
                  fsm_d   = StRun;
               end
            end
         end
         StOut: begin
            digest_valid = 1'b1;
            if (digest_ready) begin
               // Clear the whole sponge so the next message starts fresh.
               for (int unsigned i = 0; i < STATE_WORDS; i++) begin
                  state_d[i] = '0;
               end
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   // Digest is the rate portion of the state, packed like blk_data.
   always_comb begin
      digest = '0;
      for (int unsigned i = 0; i < RATE_WORDS; i++) begin
         digest[32*i +: 32] = state_q[i];
      end
   end

   assign perm_state_in  = state_q;
   assign perm_round_num = round_q;
   assign busy           = (fsm_q != StIdle);

endmodule
